// File: rtl/netwalk_execution_engine_execution_pkg.sv
// Shared encodings, field geometry and helpers for the netwalk execution engine.
// Action-set offsets index exec_action_set; header offsets index pkt_header_out.
package netwalk_execution_engine_execution_pkg;

    localparam int SET_W  = 356;
    localparam int HDR_W  = 512;
    localparam int MASK_W = 16;
    localparam int FLAG_W = 4;

    typedef enum logic [FLAG_W-1:0] {
        ACT_LOAD    = 4'b0001,
        ACT_MODIFY  = 4'b0010,
        ACT_DROP    = 4'b0100,
        ACT_TO_CTRL = 4'b1000
    } act_e;

    localparam logic [31:0] CONTROLLER_PORT = 32'hFFFF_FFFD;

    // Field widths (identical in the action set and in the header)
    localparam int W_IN_PORT  = 32;
    localparam int W_OUT_PORT = 32;
    localparam int W_ETH_DST  = 48;
    localparam int W_ETH_SRC  = 48;
    localparam int W_ETH_TYPE = 16;
    localparam int W_IP_TOS   = 8;
    localparam int W_IP_PROTO = 8;
    localparam int W_IP_SRC   = 32;
    localparam int W_IP_DST   = 32;
    localparam int W_L4_SRC   = 16;
    localparam int W_L4_DST   = 16;
    localparam int W_VLAN_ID  = 12;
    localparam int W_VLAN_PCP = 3;

    // Action-set LSB offsets
    localparam int S_IN_PORT  = 324;
    localparam int S_OUT_PORT = 292;
    localparam int S_ETH_DST  = 244;
    localparam int S_ETH_SRC  = 196;
    localparam int S_ETH_TYPE = 180;
    localparam int S_IP_TOS   = 172;
    localparam int S_IP_PROTO = 164;
    localparam int S_IP_SRC   = 132;
    localparam int S_IP_DST   = 100;
    localparam int S_L4_SRC   = 84;
    localparam int S_L4_DST   = 68;
    localparam int S_VLAN_ID  = 56;
    localparam int S_VLAN_PCP = 53;
    localparam int S_MASK     = 32;

    // Header LSB offsets
    localparam int H_ETH_DST  = 464;
    localparam int H_ETH_SRC  = 416;
    localparam int H_ETH_TYPE = 400;
    localparam int H_IP_TOS   = 392;
    localparam int H_IP_PROTO = 384;
    localparam int H_IP_SRC   = 352;
    localparam int H_IP_DST   = 320;
    localparam int H_L4_SRC   = 304;
    localparam int H_L4_DST   = 288;
    localparam int H_VLAN_ID  = 276;
    localparam int H_VLAN_PCP = 273;
    localparam int H_IN_PORT  = 224;
    localparam int H_OUT_PORT = 192;

    // Field mask bit indices; bits 15:12 carry no meaning
    localparam int MB_ETH_DST  = 0;
    localparam int MB_ETH_SRC  = 1;
    localparam int MB_ETH_TYPE = 2;
    localparam int MB_IP_TOS   = 3;
    localparam int MB_IP_PROTO = 4;
    localparam int MB_IP_SRC   = 5;
    localparam int MB_IP_DST   = 6;
    localparam int MB_L4_SRC   = 7;
    localparam int MB_L4_DST   = 8;
    localparam int MB_VLAN_ID  = 9;
    localparam int MB_VLAN_PCP = 10;
    localparam int MB_OUT_PORT = 11;
    localparam int MB_USED     = 12;

    // Relocates every action-set field to its header position; unused header bits are zero.
    function automatic logic [HDR_W-1:0] hdr_from_set(input logic [SET_W-1:0] s);
        logic [HDR_W-1:0] h;
        h = '0;
        h[H_ETH_DST  +: W_ETH_DST ] = s[S_ETH_DST  +: W_ETH_DST ];
        h[H_ETH_SRC  +: W_ETH_SRC ] = s[S_ETH_SRC  +: W_ETH_SRC ];
        h[H_ETH_TYPE +: W_ETH_TYPE] = s[S_ETH_TYPE +: W_ETH_TYPE];
        h[H_IP_TOS   +: W_IP_TOS  ] = s[S_IP_TOS   +: W_IP_TOS  ];
        h[H_IP_PROTO +: W_IP_PROTO] = s[S_IP_PROTO +: W_IP_PROTO];
        h[H_IP_SRC   +: W_IP_SRC  ] = s[S_IP_SRC   +: W_IP_SRC  ];
        h[H_IP_DST   +: W_IP_DST  ] = s[S_IP_DST   +: W_IP_DST  ];
        h[H_L4_SRC   +: W_L4_SRC  ] = s[S_L4_SRC   +: W_L4_SRC  ];
        h[H_L4_DST   +: W_L4_DST  ] = s[S_L4_DST   +: W_L4_DST  ];
        h[H_VLAN_ID  +: W_VLAN_ID ] = s[S_VLAN_ID  +: W_VLAN_ID ];
        h[H_VLAN_PCP +: W_VLAN_PCP] = s[S_VLAN_PCP +: W_VLAN_PCP];
        h[H_IN_PORT  +: W_IN_PORT ] = s[S_IN_PORT  +: W_IN_PORT ];
        h[H_OUT_PORT +: W_OUT_PORT] = s[S_OUT_PORT +: W_OUT_PORT];
        return h;
    endfunction

endpackage

// File: rtl/netwalk_execution_engine_execution_merge.sv
// Masked field merge: each header field takes the action-set value when its
// mask bit is set, otherwise keeps the old header value. in_port is never masked.
module netwalk_header_field_merge
    import netwalk_execution_engine_execution_pkg::*;
(
    input  logic [HDR_W-1:0]   i_old_hdr,
    input  logic [SET_W-1:0]   i_action_set,
    input  logic [MB_USED-1:0] i_mask,
    output logic [HDR_W-1:0]   o_merged_hdr
);

    logic [HDR_W-1:0] w_new_hdr;

    assign w_new_hdr = hdr_from_set(i_action_set);

    always_comb begin
        o_merged_hdr = i_old_hdr;
        if (i_mask[MB_ETH_DST])
            o_merged_hdr[H_ETH_DST +: W_ETH_DST] = w_new_hdr[H_ETH_DST +: W_ETH_DST];
        if (i_mask[MB_ETH_SRC])
            o_merged_hdr[H_ETH_SRC +: W_ETH_SRC] = w_new_hdr[H_ETH_SRC +: W_ETH_SRC];
        if (i_mask[MB_ETH_TYPE])
            o_merged_hdr[H_ETH_TYPE +: W_ETH_TYPE] = w_new_hdr[H_ETH_TYPE +: W_ETH_TYPE];
        if (i_mask[MB_IP_TOS])
            o_merged_hdr[H_IP_TOS +: W_IP_TOS] = w_new_hdr[H_IP_TOS +: W_IP_TOS];
        if (i_mask[MB_IP_PROTO])
            o_merged_hdr[H_IP_PROTO +: W_IP_PROTO] = w_new_hdr[H_IP_PROTO +: W_IP_PROTO];
        if (i_mask[MB_IP_SRC])
            o_merged_hdr[H_IP_SRC +: W_IP_SRC] = w_new_hdr[H_IP_SRC +: W_IP_SRC];
        if (i_mask[MB_IP_DST])
            o_merged_hdr[H_IP_DST +: W_IP_DST] = w_new_hdr[H_IP_DST +: W_IP_DST];
        if (i_mask[MB_L4_SRC])
            o_merged_hdr[H_L4_SRC +: W_L4_SRC] = w_new_hdr[H_L4_SRC +: W_L4_SRC];
        if (i_mask[MB_L4_DST])
            o_merged_hdr[H_L4_DST +: W_L4_DST] = w_new_hdr[H_L4_DST +: W_L4_DST];
        if (i_mask[MB_VLAN_ID])
            o_merged_hdr[H_VLAN_ID +: W_VLAN_ID] = w_new_hdr[H_VLAN_ID +: W_VLAN_ID];
        if (i_mask[MB_VLAN_PCP])
            o_merged_hdr[H_VLAN_PCP +: W_VLAN_PCP] = w_new_hdr[H_VLAN_PCP +: W_VLAN_PCP];
        if (i_mask[MB_OUT_PORT])
            o_merged_hdr[H_OUT_PORT +: W_OUT_PORT] = w_new_hdr[H_OUT_PORT +: W_OUT_PORT];
    end

endmodule

// File: rtl/netwalk_execution_engine_execution.sv
// Packet header execution engine: applies one LOAD/MODIFY/DROP/TO_CONTROLLER
// action per enabled cycle to a 512-bit header register with a one-cycle emit strobe.
module netwalk_execution_engine_execution
    import netwalk_execution_engine_execution_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [FLAG_W-1:0] exec_action_flag,
    input  logic [SET_W-1:0]  exec_action_set,
    input  logic              exec_action_enable,
    output logic [HDR_W-1:0]  pkt_header_out,
    output logic              packet_out_enable
);

    logic [HDR_W-1:0] r_hdr;
    logic             r_strobe;
    logic [HDR_W-1:0] w_hdr_nxt;
    logic             w_strobe_nxt;
    logic [HDR_W-1:0] w_merged_hdr;

    netwalk_header_field_merge u_merge (
        .i_old_hdr    (r_hdr),
        .i_action_set (exec_action_set),
        .i_mask       (exec_action_set[S_MASK +: MB_USED]),
        .o_merged_hdr (w_merged_hdr)
    );

    // Zero and multi-hot flags fall to the default: hold header, no strobe.
    always_comb begin
        w_hdr_nxt    = r_hdr;
        w_strobe_nxt = 1'b0;
        if (exec_action_enable) begin
            case (exec_action_flag)
                ACT_LOAD: begin
                    w_hdr_nxt    = hdr_from_set(exec_action_set);
                    w_strobe_nxt = 1'b1;
                end
                ACT_MODIFY: begin
                    w_hdr_nxt    = w_merged_hdr;
                    w_strobe_nxt = 1'b1;
                end
                ACT_DROP: begin
                    w_hdr_nxt    = '0;
                    w_strobe_nxt = 1'b0;
                end
                ACT_TO_CTRL: begin
                    w_hdr_nxt[H_OUT_PORT +: W_OUT_PORT] = CONTROLLER_PORT;
                    w_strobe_nxt = 1'b1;
                end
                default: begin
                    w_hdr_nxt    = r_hdr;
                    w_strobe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hdr    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_hdr    <= w_hdr_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign pkt_header_out    = r_hdr;
    assign packet_out_enable = r_strobe;

endmodule

// File: tb/tb_netwalk_execution_engine_execution.sv
// Scoreboard bench: a field-level reference model queues the expected header/strobe
// per clock edge; a monitor pops and compares one entry after every rising edge.
module tb_netwalk_execution_engine_execution;

    logic         clk;
    logic         reset;
    logic [3:0]   exec_action_flag;
    logic [355:0] exec_action_set;
    logic         exec_action_enable;
    logic [511:0] pkt_header_out;
    logic         packet_out_enable;

    int n_tests = 0;
    int n_fail  = 0;

    // Field table: 0..11 follow mask bit order, 12 is in_port (never masked)
    int slo [13] = '{244, 196, 180, 172, 164, 132, 100, 84, 68, 56, 53, 292, 324};
    int hlo [13] = '{464, 416, 400, 392, 384, 352, 320, 304, 288, 276, 273, 192, 224};
    int wid [13] = '{48, 48, 16, 8, 8, 32, 32, 16, 16, 12, 3, 32, 32};

    logic [47:0]  mf [13];
    logic [511:0] q_hdr [$];
    logic         q_stb [$];

    netwalk_execution_engine_execution dut (
        .clk                (clk),
        .reset              (reset),
        .exec_action_flag   (exec_action_flag),
        .exec_action_set    (exec_action_set),
        .exec_action_enable (exec_action_enable),
        .pkt_header_out     (pkt_header_out),
        .packet_out_enable  (packet_out_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] get_field(input logic [355:0] s, input int k);
        logic [47:0] v;
        v = '0;
        for (int b = 0; b < wid[k]; b++) v[b] = s[slo[k] + b];
        return v;
    endfunction

    function automatic logic [355:0] put_field(input logic [355:0] s, input int k, input logic [47:0] v);
        logic [355:0] r;
        r = s;
        for (int b = 0; b < wid[k]; b++) r[slo[k] + b] = v[b];
        return r;
    endfunction

    function automatic logic [511:0] model_hdr();
        logic [511:0] h;
        h = '0;
        for (int k = 0; k < 13; k++)
            for (int b = 0; b < wid[k]; b++) h[hlo[k] + b] = mf[k][b];
        return h;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 13; k++) mf[k] = '0;
    endtask

    task automatic model_apply(input logic [3:0] f, input logic [355:0] s, input logic e,
                               output logic stb);
        stb = 1'b0;
        if (e) begin
            if (f == 4'b0001) begin
                for (int k = 0; k < 13; k++) mf[k] = get_field(s, k);
                stb = 1'b1;
            end else if (f == 4'b0010) begin
                for (int k = 0; k < 12; k++) if (s[32 + k]) mf[k] = get_field(s, k);
                stb = 1'b1;
            end else if (f == 4'b0100) begin
                model_clear();
            end else if (f == 4'b1000) begin
                mf[11] = 48'hFFFF_FFFD;
                stb = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [3:0] f, input logic [355:0] s, input logic e);
        logic stb;
        @(negedge clk);
        exec_action_flag   = f;
        exec_action_set    = s;
        exec_action_enable = e;
        model_apply(f, s, e, stb);
        q_hdr.push_back(model_hdr());
        q_stb.push_back(stb);
    endtask

    function automatic logic [355:0] rand_set();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        return t[355:0];
    endfunction

    task automatic check_reset_zero(input string tag);
        n_tests++;
        if (pkt_header_out !== 512'h0) begin
            n_fail++;
            $display("FAIL %s_hdr got %h want 0", tag, pkt_header_out);
        end
        n_tests++;
        if (packet_out_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stb got %b want 0", tag, packet_out_enable);
        end
    endtask

    // Monitor: one expected entry per enabled-or-idle edge driven through step()
    initial begin
        logic [511:0] eh;
        logic         es;
        forever begin
            @(posedge clk);
            #1;
            if (reset && q_hdr.size() > 0) begin
                eh = q_hdr.pop_front();
                es = q_stb.pop_front();
                n_tests++;
                if (packet_out_enable !== es) begin
                    n_fail++;
                    $display("FAIL strobe got %b want %b at %0t", packet_out_enable, es, $time);
                end
                n_tests++;
                if (pkt_header_out !== eh) begin
                    n_fail++;
                    $display("FAIL header got %h want %h", pkt_header_out, eh);
                end
            end
        end
    end

    initial begin
        logic [355:0] s;
        logic [3:0]   f;
        model_clear();
        reset              = 1'b0;
        exec_action_flag   = 4'b0;
        exec_action_set    = '0;
        exec_action_enable = 1'b0;
        #1;
        check_reset_zero("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // LOAD with the listed fields, then one idle cycle (strobe drops)
        s = '0;
        s = put_field(s, 2, 48'h0800);
        s = put_field(s, 5, 48'h2b61934c);
        s = put_field(s, 12, 48'h72);
        step(4'b0001, s, 1'b1);
        step(4'b0000, rand_set(), 1'b0);

        // MODIFY only ip_src, every other field randomized
        s = rand_set();
        s[47:32] = 16'h0020;
        s = put_field(s, 5, 48'h0a000001);
        step(4'b0010, s, 1'b1);

        step(4'b1000, rand_set(), 1'b1);
        step(4'b0100, rand_set(), 1'b1);
        step(4'b0001, rand_set(), 1'b1);
        step(4'b0011, rand_set(), 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, rand_set(), 1'b1);
        step(4'b0001, rand_set(), 1'b0);

        // Reset asserted between drive and edge: the pending LOAD is discarded
        @(negedge clk);
        exec_action_flag   = 4'b0001;
        exec_action_set    = rand_set();
        exec_action_enable = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_zero("async_rst");
        @(posedge clk);
        #1;
        check_reset_zero("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        exec_action_enable = 1'b0;
        model_clear();
        step(4'b0000, rand_set(), 1'b0);
        step(4'b0001, rand_set(), 1'b1);

        // Randomized mix of actions, masks, invalid flags and idle cycles
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: f = 4'b0001;
                1, 2: f = 4'b0010;
                3: f = 4'b0100;
                4: f = 4'b1000;
                default: f = 4'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) f = 4'b0100 ^ 4'b0100;
            s = rand_set();
            step(f, s, ($urandom_range(0, 3) != 0));
        end
        step(4'b0000, '0, 1'b0);

        @(posedge clk);
        #3;
        n_tests++;
        if (q_hdr.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q_hdr.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
